// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown/alarm controller.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  // Highest-priority button pulse seen this cycle.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_START,
    EV_STOP,
    EV_CLEAR,
    EV_LOAD
  } event_e;

  localparam int NUM_BTN   = 4;
  localparam int BTN_START = 0;
  localparam int BTN_STOP  = 1;
  localparam int BTN_CLEAR = 2;
  localparam int BTN_LOAD  = 3;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; entry 9 is the leftmost.
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return (d > 4'd9) ? SEG_ZERO : SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD register with clamped load, borrow-chain decrement and
// zero/one flags.
module bcd_down_counter #(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic                dec_i,
  input  logic [4*DIGITS-1:0] load_bcd_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic                is_zero_o,
  output logic                is_one_o
);

  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, clamp, decr;

  always_comb begin
    logic brw;
    brw = 1'b1;
    clamp = '0;
    decr = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamp[i] = (load_bcd_i[4*i +: 4] > 4'd9) ? 4'd9 : load_bcd_i[4*i +: 4];
      if (brw) begin
        decr[i] = (cnt_q[i] == 4'd0) ? 4'd9 : cnt_q[i] - 4'd1;
        brw     = (cnt_q[i] == 4'd0);
      end else begin
        decr[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = clamp;
    else if (dec_i)  cnt_d = decr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o   = cnt_q;
  assign is_zero_o = (cnt_q == '0);
  assign is_one_o  = (cnt_q == (4*DIGITS)'(1));

endmodule

// File: rtl/countdown_alarm_ctrl.sv
// Countdown/alarm front-end: button sync, run/pause/alarm FSM, tick and beep
// dividers, LED rotator and registered seven-segment outputs.
module countdown_alarm_ctrl
  import countdown_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int DIGITS      = 6,
  parameter int LIGHTS      = 6,
  parameter int BEEP_HZ     = 1000,
  parameter int ALARM_TICKS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_start,
  input  logic                btn_stop,
  input  logic                btn_clear,
  input  logic                btn_load,
  input  logic [4*DIGITS-1:0] load_bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                buzzer,
  output logic [LIGHTS-1:0]   light,
  output logic [1:0]          state_o
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int BEEP_DIV = CLK_HZ / (2 * BEEP_HZ);
  localparam int PW       = $clog2(TICK_DIV);
  localparam int BW       = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int AW       = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  logic [NUM_BTN-1:0] btn_raw, sync1_q, sync2_q, prev_q, pulse;
  state_e             state_q, state_d;
  event_e             ev;
  logic [PW-1:0]      presc_q, presc_d, presc_inc;
  logic               tick;
  logic [AW-1:0]      alarm_q, alarm_d;
  logic [BW-1:0]      beep_q, beep_d;
  logic               buzz_q, buzz_d;
  logic [LIGHTS-1:0]  rot_q, rot_d;
  logic [7*DIGITS-1:0] seg_q, seg_d;
  logic [4*DIGITS-1:0] count;
  logic               cnt_zero, cnt_one, cnt_clr, cnt_load, cnt_dec;

  // Two-flop synchroniser plus one history flop for rising-edge detection.
  assign btn_raw = {btn_load, btn_clear, btn_stop, btn_start};
  assign pulse   = sync2_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    ev = EV_NONE;
    if (pulse[BTN_CLEAR])      ev = EV_CLEAR;
    else if (pulse[BTN_STOP])  ev = EV_STOP;
    else if (pulse[BTN_START]) ev = EV_START;
    else if (pulse[BTN_LOAD])  ev = EV_LOAD;
  end

  bcd_down_counter #(.DIGITS(DIGITS)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_bcd_i (load_bcd),
    .count_o    (count),
    .is_zero_o  (cnt_zero),
    .is_one_o   (cnt_one)
  );

  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign presc_inc = tick ? '0 : presc_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    alarm_d  = alarm_q;
    rot_d    = rot_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (ev == EV_CLEAR) begin
      state_d = ST_IDLE;
      presc_d = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = '0;
          if (ev == EV_START && !cnt_zero) begin
            state_d = ST_RUN;
            rot_d   = LIGHTS'(1);
          end else if (ev == EV_LOAD) begin
            cnt_load = 1'b1;
          end
        end
        ST_RUN: begin
          if (ev == EV_STOP) begin
            state_d = ST_PAUSE;
          end else begin
            presc_d = presc_inc;
            if (tick) begin
              // A zero count can only arrive here via a PAUSE-time load of 0.
              if (cnt_one || cnt_zero) begin
                state_d = ST_ALARM;
                alarm_d = '0;
                cnt_clr = 1'b1;
              end else begin
                cnt_dec = 1'b1;
                rot_d   = {rot_q[LIGHTS-2:0], rot_q[LIGHTS-1]};
              end
            end
          end
        end
        ST_PAUSE: begin
          if (ev == EV_START)     state_d = ST_RUN;
          else if (ev == EV_LOAD) cnt_load = 1'b1;
        end
        ST_ALARM: begin
          if (ev != EV_NONE) begin
            state_d = ST_IDLE;
            presc_d = '0;
          end else begin
            presc_d = presc_inc;
            if (tick) begin
              if (alarm_q == AW'(ALARM_TICKS - 1)) state_d = ST_IDLE;
              else                                 alarm_d = alarm_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Beep divider restarts whenever the previous cycle was outside ALARM.
  always_comb begin
    beep_d = '0;
    buzz_d = 1'b0;
    if (state_q == ST_ALARM) begin
      if (beep_q == BW'(BEEP_DIV - 1)) begin
        beep_d = '0;
        buzz_d = ~buzz_q;
      end else begin
        beep_d = beep_q + 1'b1;
        buzz_d = buzz_q;
      end
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign seg_d[7*i +: 7] = seg_decode(count[4*i +: 4]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      alarm_q <= '0;
      beep_q  <= '0;
      buzz_q  <= 1'b0;
      rot_q   <= '0;
      seg_q   <= {DIGITS{SEG_ZERO}};
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      alarm_q <= alarm_d;
      beep_q  <= beep_d;
      buzz_q  <= buzz_d;
      rot_q   <= rot_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_RUN, ST_PAUSE: light = rot_q;
      ST_ALARM:         light = {LIGHTS{buzz_q}};
      default:          light = '0;
    endcase
  end

  assign seg     = seg_q;
  assign buzzer  = buzz_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_countdown_alarm_ctrl.sv
// Random + directed stimulus against an integer-arithmetic reference model,
// compared every cycle on state, segments, buzzer and LEDs.
module tb_countdown_alarm_ctrl;

  localparam int DIGITS = 2;
  localparam int LIGHTS = 4;
  localparam int TD     = 10;
  localparam int BD     = 2;
  localparam int AT     = 3;
  localparam logic [3:0] S = 4'b0001, P = 4'b0010, C = 4'b0100, L = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_start = 1'b0, btn_stop = 1'b0, btn_clear = 1'b0, btn_load = 1'b0;
  logic [4*DIGITS-1:0] load_bcd = '0;
  logic [7*DIGITS-1:0] seg;
  logic                buzzer;
  logic [LIGHTS-1:0]   light;
  logic [1:0]          state_o;

  countdown_alarm_ctrl #(
    .CLK_HZ(100), .TICK_HZ(10), .DIGITS(DIGITS), .LIGHTS(LIGHTS),
    .BEEP_HZ(25), .ALARM_TICKS(AT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_clear(btn_clear), .btn_load(btn_load),
    .load_bcd(load_bcd), .seg(seg), .buzzer(buzzer),
    .light(light), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int SEGT[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

  function automatic int seg_of(input int v);
    int r = 0, p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r |= SEGT[(v / p) % 10] << (7 * i);
      p *= 10;
    end
    return r;
  endfunction

  function automatic int clamp_of(input logic [4*DIGITS-1:0] b);
    int r = 0, p = 1, d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'((b >> (4 * i)) & 'hF);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  // Reference model: states 0..3 as integers, count as a decimal integer.
  int m_st, m_cnt, m_presc, m_alarm, m_beep, m_rot, m_seg;
  bit m_buzz;
  logic [3:0] h0, h1, h2;

  always @(posedge clk) begin : model
    logic [3:0] cur, pl;
    int ev, exp_light;
    bit tick;
    cur = {btn_load, btn_clear, btn_stop, btn_start};
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_presc = 0; m_alarm = 0; m_beep = 0;
      m_buzz = 0; m_rot = 1; m_seg = seg_of(0);
      h0 = '0; h1 = '0; h2 = '0;
    end else begin
      // A press is acted on at the third edge after the input rises.
      pl = h1 & ~h2;
      h2 = h1; h1 = h0; h0 = cur;
      ev = pl[2] ? 3 : pl[1] ? 2 : pl[0] ? 1 : pl[3] ? 4 : 0;
      m_seg = seg_of(m_cnt);
      if (m_st != 3) begin
        m_beep = 0; m_buzz = 0;
      end else if (m_beep == BD - 1) begin
        m_beep = 0; m_buzz = !m_buzz;
      end else m_beep++;
      tick = (m_presc == TD - 1);
      if (ev == 3) begin
        m_st = 0; m_cnt = 0; m_presc = 0;
      end else begin
        case (m_st)
          0: begin
            m_presc = 0;
            if (ev == 1 && m_cnt != 0) begin m_st = 1; m_rot = 1; end
            else if (ev == 4) m_cnt = clamp_of(load_bcd);
          end
          1: begin
            if (ev == 2) m_st = 2;
            else begin
              m_presc = tick ? 0 : m_presc + 1;
              if (tick) begin
                if (m_cnt <= 1) begin m_cnt = 0; m_st = 3; m_alarm = 0; end
                else begin m_cnt--; m_rot = (m_rot == 8) ? 1 : m_rot * 2; end
              end
            end
          end
          2: begin
            if (ev == 1) m_st = 1;
            else if (ev == 4) m_cnt = clamp_of(load_bcd);
          end
          default: begin
            if (ev != 0) begin m_st = 0; m_presc = 0; end
            else begin
              m_presc = tick ? 0 : m_presc + 1;
              if (tick) begin
                m_alarm++;
                if (m_alarm == AT) m_st = 0;
              end
            end
          end
        endcase
      end
    end
    #1;
    exp_light = (m_st == 0) ? 0 : (m_st == 3) ? (m_buzz ? 15 : 0) : m_rot;
    chk("state", 32'(state_o), m_st);
    chk("seg", 32'(seg), m_seg);
    chk("buzzer", 32'(buzzer), 32'(m_buzz));
    chk("light", 32'(light), exp_light);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    @(negedge clk);
    {btn_load, btn_clear, btn_stop, btn_start} = m;
    repeat (hold) @(negedge clk);
    {btn_load, btn_clear, btn_stop, btn_start} = 4'b0;
  endtask

  initial begin
    int r;
    {btn_load, btn_clear, btn_stop, btn_start} = 4'($urandom);
    @(negedge clk);
    {btn_load, btn_clear, btn_stop, btn_start} = 4'($urandom);
    @(negedge clk);
    rst_n = 1'b1;
    {btn_load, btn_clear, btn_stop, btn_start} = 4'b0;
    idle(3);

    load_bcd = 8'h3F; press(L, 1); idle(5);
    press(S, 1); idle(25);
    load_bcd = 8'h12; press(L, 2); idle(20);
    press(C, 1); idle(5);

    load_bcd = 8'h10; press(L, 1); idle(4);
    press(S, 1); idle(150);

    load_bcd = 8'h02; press(L, 1); idle(4);
    press(S, 1); idle(28); press(P, 1); idle(10);

    load_bcd = 8'h05; press(L, 1); idle(4);
    press(S, 1); idle(14); press(P, 1); idle(50);
    press(S, 1); idle(80);

    press(C, 1); idle(4); press(S, 1); idle(5);
    load_bcd = 8'h05; press(L, 1); idle(4);
    press(S, 1); idle(12); press(C | P, 1); idle(5);

    for (int k = 0; k < 400; k++) begin
      r = int'($urandom_range(0, 9));
      if (k % 97 == 50) begin
        @(negedge clk); rst_n = 1'b0;
        idle(2); rst_n = 1'b1;
      end else if (r < 6) begin
        idle(int'($urandom_range(1, (r == 0) ? 150 : 20)));
      end else if (r < 9) begin
        load_bcd = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
        press(4'(1 << $urandom_range(0, 3)), int'($urandom_range(1, 4)));
      end else begin
        load_bcd = 8'($urandom);
        press(4'($urandom_range(1, 15)), int'($urandom_range(1, 4)));
      end
    end
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
